// File: rtl/hs_pkg.sv
// Shared types for the handshake RAM responder: FSM states, op codes, error classes, parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a. Build option HS_RAM_PARITY_EN widens RAM words to 36 bits (per-byte parity).
package hs_pkg;

   // FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Captured operation
   typedef enum logic [1:0] {
      OP_RD  = 2'd0,
      OP_WR  = 2'd1,
      OP_BAD = 2'd2
   } op_t;

   // Error class decided at capture
   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_RANGE = 2'd1,
      ERR_ALIGN = 2'd2,
      ERR_PROTO = 2'd3
   } err_t;

`ifdef HS_RAM_PARITY_EN
   localparam int RAM_W = 36;
`else
   localparam int RAM_W = 32;
`endif

   // Even parity per byte: bit i makes byte i plus its parity bit an even count of ones.
   function automatic logic [3:0] byte_parity(input logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) begin
         p[i] = ^d[8*i +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/hs_ram_array.sv
// Single-port synchronous RAM, RAM_W bits wide (32, or 36 with HS_RAM_PARITY_EN), no reset.
// Latency: read data appears one clock after en_i with we_i low.
// Backpressure: none; one access per enabled cycle.
// Ports: clk_i clock; en_i access enable; we_i write (else read); addr_i word index;
//        wdata_i write word; rdata_o registered read word.
module hs_ram_array
   import hs_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic             clk_i,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [RAM_W-1:0] wdata_i,
   output logic [RAM_W-1:0] rdata_o
);

   logic [RAM_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem[addr_i] <= wdata_i;
         end else begin
            rdata_o <= mem[addr_i];
         end
      end
   end

endmodule

// File: rtl/hs_ram_responder.sv
// Handshake-bus RAM target: decodes a word window, inserts WAIT_STATES, serves reads/writes from RAM.
// Latency: hs_ready_o high WAIT_STATES+2 cycles after the request is first seen in IDLE.
// Backpressure: initiator holds rd/wr until ready; requests are ignored outside IDLE.
// Ports: clk_i, rst_i (async, active-high); hs_rd_i/hs_wr_i request; hs_addr_i byte address;
//        hs_data_i write data; hs_ready_o idle-free/complete; hs_data_o read data; hs_err_o error.
// Build option HS_RAM_PARITY_EN: per-byte parity in RAM plus par_inject_i to corrupt bit-0 parity.
module hs_ram_responder
   import hs_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hs_rd_i,
   input  logic        hs_wr_i,
   input  logic [31:0] hs_addr_i,
   input  logic [31:0] hs_data_i,
`ifdef HS_RAM_PARITY_EN
   input  logic        par_inject_i,
`endif
   output logic        hs_ready_o,
   output logic [31:0] hs_data_o,
   output logic        hs_err_o
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WS        = 4'(WAIT_STATES);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q;
   op_t               op_q, op_in;
   err_t              err_q, err_in;
   logic [AW-1:0]     idx_q;
   logic [31:0]       wdata_q;
   logic [31:0]       data_q;
   logic              capture, ram_en, ram_we;
   logic [31:0]       offset;
   logic [RAM_W-1:0]  ram_wdata, ram_rdata;
   logic              rd_good, par_err;

   // Wrap below BASE_ADDR yields a huge offset, so one compare covers both window edges.
   assign offset = hs_addr_i - BASE_ADDR;

   always_comb begin
      op_in  = OP_RD;
      err_in = ERR_NONE;
      if (hs_rd_i && hs_wr_i) begin
         op_in  = OP_BAD;
         err_in = ERR_PROTO;
      end else if (hs_wr_i) begin
         op_in = OP_WR;
      end
      if (op_in != OP_BAD) begin
         if (offset >= WIN_BYTES) begin
            err_in = ERR_RANGE;
         end else if (hs_addr_i[1:0] != 2'b00) begin
            err_in = ERR_ALIGN;
         end
      end
   end

   // Next state and RAM strobes
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      ram_en  = 1'b0;
      ram_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hs_rd_i || hs_wr_i) begin
               capture = 1'b1;
               state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (cnt_q == WS) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // Errored transactions never touch the array.
            ram_en  = (err_q == ERR_NONE);
            ram_we  = (op_q == OP_WR);
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign rd_good = (op_q == OP_RD) && (err_q == ERR_NONE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_WAIT) begin
            cnt_q <= (cnt_q == WS) ? 4'd0 : cnt_q + 4'd1;
         end else if (capture) begin
            cnt_q <= (state_d == ST_WAIT) ? 4'd1 : 4'd0;
         end
         // Erroring reads and protocol errors return zero; writes leave the data output alone.
         if (state_q == ST_ACCESS && op_q != OP_WR && err_q != ERR_NONE) begin
            data_q <= 32'h0;
         end else if (state_q == ST_DONE && rd_good) begin
            data_q <= ram_rdata[31:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q    <= OP_RD;
         err_q   <= ERR_NONE;
         idx_q   <= '0;
         wdata_q <= 32'h0;
      end else if (capture) begin
         op_q    <= op_in;
         err_q   <= err_in;
         idx_q   <= offset[AW+1:2];
         wdata_q <= hs_data_i;
      end
   end

`ifdef HS_RAM_PARITY_EN
   logic inj_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         inj_q <= 1'b0;
      end else if (capture) begin
         inj_q <= par_inject_i;
      end
   end

   assign ram_wdata = {byte_parity(wdata_q) ^ {3'b000, inj_q}, wdata_q};
   assign par_err   = (byte_parity(ram_rdata[31:0]) != ram_rdata[35:32]);
`else
   assign ram_wdata = wdata_q;
   assign par_err   = 1'b0;
`endif

   hs_ram_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (idx_q),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // RAM read data is valid only in DONE, so a good read bypasses the holding register there.
   assign hs_ready_o = ((state_q == ST_IDLE) && !hs_rd_i && !hs_wr_i) || (state_q == ST_DONE);
   assign hs_data_o  = ((state_q == ST_DONE) && rd_good) ? ram_rdata[31:0] : data_q;
   assign hs_err_o   = (state_q == ST_DONE) &&
                       ((err_q != ERR_NONE) || (rd_good && par_err));

endmodule

// File: tb/tb_hs_ram_responder.sv
module tb_hs_ram_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_rd, a_wr, a_rdy, a_err;
   logic [31:0] a_addr, a_wdat, a_rdat;
   logic        b_rd, b_wr, b_rdy, b_err;
   logic [31:0] b_addr, b_wdat, b_rdat;
`ifdef HS_RAM_PARITY_EN
   logic        a_inj, b_inj;
`endif

   hs_ram_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .hs_rd_i(a_rd), .hs_wr_i(a_wr), .hs_addr_i(a_addr),
      .hs_data_i(a_wdat),
`ifdef HS_RAM_PARITY_EN
      .par_inject_i(a_inj),
`endif
      .hs_ready_o(a_rdy), .hs_data_o(a_rdat), .hs_err_o(a_err));

   hs_ram_responder #(.BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .hs_rd_i(b_rd), .hs_wr_i(b_wr), .hs_addr_i(b_addr),
      .hs_data_i(b_wdat),
`ifdef HS_RAM_PARITY_EN
      .par_inject_i(b_inj),
`endif
      .hs_ready_o(b_rdy), .hs_data_o(b_rdat), .hs_err_o(b_err));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          dut_b;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic        inj;
      int          lat;
      logic [31:0] data;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input bit dut_b, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdat, input logic inj,
                               input int lat, input logic [31:0] data, input logic err);
      vec_t v;
      v.dut_b = dut_b; v.rd = rd; v.wr = wr; v.addr = addr; v.wdat = wdat; v.inj = inj;
      v.lat = lat; v.data = data; v.err = err;
      return v;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input bit dut_b, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdat, input logic inj);
      if (dut_b) begin
         b_rd = rd; b_wr = wr; b_addr = addr; b_wdat = wdat;
`ifdef HS_RAM_PARITY_EN
         b_inj = inj;
`endif
      end else begin
         a_rd = rd; a_wr = wr; a_addr = addr; a_wdat = wdat;
`ifdef HS_RAM_PARITY_EN
         a_inj = inj;
`endif
      end
      if (inj === 1'bx) $display("note: inj unknown");
   endtask

   // Issues one request, counts cycles until ready, samples the completion, then drops the request.
   task automatic run_txn(input bit dut_b, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic inj,
                          output int lat, output logic [31:0] rdat, output logic rerr,
                          output logic leak);
      logic rdy, e;
      logic [31:0] d;
      @(posedge clk); #1;
      drive(dut_b, rd, wr, addr, wdat, inj);
      lat = -1; rdat = 32'h0; rerr = 1'b0; leak = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         rdy = dut_b ? b_rdy : a_rdy;
         d   = dut_b ? b_rdat : a_rdat;
         e   = dut_b ? b_err : a_err;
         if (rdy) begin
            lat = k; rdat = d; rerr = e;
            break;
         end else if (e) begin
            leak = 1'b1;
         end
      end
      drive(dut_b, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   int          lat;
   logic [31:0] rdat;
   logic        rerr, leak;

   initial begin
      // A-side: WAIT_STATES=2, base 0, 1024 words (window ends at 0x1000)
      vecs.push_back(mk(0, 1, 0, 32'h0000_0010, 32'h0,          0, 4, 32'hCAFE_F00D, 0));
      vecs.push_back(mk(0, 0, 1, 32'h0000_0000, 32'h1111_1111,  0, 4, 32'hCAFE_F00D, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0000_1000, 32'h0,          0, 4, 32'h0,         1));
      vecs.push_back(mk(0, 0, 1, 32'h0000_0002, 32'hDEAD_BEEF,  0, 4, 32'h0,         1));
      vecs.push_back(mk(0, 1, 0, 32'h0000_0000, 32'h0,          0, 4, 32'h1111_1111, 0));
      vecs.push_back(mk(0, 0, 1, 32'h0000_0FFC, 32'h2222_2222,  0, 4, 32'h1111_1111, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0000_0FFC, 32'h0,          0, 4, 32'h2222_2222, 0));
      vecs.push_back(mk(0, 0, 1, 32'h0000_0008, 32'h3333_3333,  0, 4, 32'h2222_2222, 0));
      vecs.push_back(mk(0, 1, 1, 32'h0000_0008, 32'h4444_4444,  0, 4, 32'h0,         1));
      vecs.push_back(mk(0, 1, 0, 32'h0000_0008, 32'h0,          0, 4, 32'h3333_3333, 0));
      vecs.push_back(mk(0, 1, 0, 32'hFFFF_FFFC, 32'h0,          0, 4, 32'h0,         1));
      vecs.push_back(mk(0, 1, 0, 32'h0000_0005, 32'h0,          0, 4, 32'h0,         1));
      // B-side: WAIT_STATES=0, base 0x1000, 16 words (window 0x1000..0x103F)
      vecs.push_back(mk(1, 0, 1, 32'h0000_1000, 32'h1234_5678,  0, 2, 32'h0,         0));
      vecs.push_back(mk(1, 1, 0, 32'h0000_1000, 32'h0,          0, 2, 32'h1234_5678, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0000_0FFC, 32'h0,          0, 2, 32'h0,         1));
      vecs.push_back(mk(1, 0, 1, 32'h0000_103C, 32'hABCD_0001,  0, 2, 32'h0,         0));
      vecs.push_back(mk(1, 1, 0, 32'h0000_103C, 32'h0,          0, 2, 32'hABCD_0001, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0000_1040, 32'h0,          0, 2, 32'h0,         1));
      vecs.push_back(mk(1, 1, 0, 32'h0000_1000, 32'h0,          0, 2, 32'h1234_5678, 0));
`ifdef HS_RAM_PARITY_EN
      vecs.push_back(mk(0, 0, 1, 32'h0000_0020, 32'hA5A5_A5A5,  1, 4, 32'h0,         0));
      vecs.push_back(mk(0, 1, 0, 32'h0000_0020, 32'h0,          0, 4, 32'hA5A5_A5A5, 1));
      vecs.push_back(mk(0, 0, 1, 32'h0000_0020, 32'hA5A5_A5A5,  0, 4, 32'hA5A5_A5A5, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0000_0020, 32'h0,          0, 4, 32'hA5A5_A5A5, 0));
`endif

      // Reset with both initiators idle
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check32("rst_ready_a", 32'(a_rdy), 32'd1);
      check32("rst_data_a",  a_rdat,     32'h0);
      check32("rst_err_a",   32'(a_err), 32'd0);
      check32("rst_ready_b", 32'(b_rdy), 32'd1);

      // Seed word 0x40, then reset in the middle of an overwrite
      run_txn(0, 1'b0, 1'b1, 32'h40, 32'h5555_5555, 1'b0, lat, rdat, rerr, leak);
      check32("seed_lat", 32'(lat), 32'd4);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 32'h40, 32'h6666_6666, 1'b0);
      @(posedge clk); #1;                       // now in the first wait cycle
      check32("midwait_busy", 32'(a_rdy), 32'd0);
      rst = 1'b1;
      #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      check32("midrst_ready", 32'(a_rdy), 32'd1);
      check32("midrst_err",   32'(a_err), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      check32("postrst_ready", 32'(a_rdy), 32'd1);
      run_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, lat, rdat, rerr, leak);
      check32("postrst_lat",  32'(lat),  32'd4);
      check32("postrst_data", rdat,      32'h5555_5555);
      check32("postrst_err",  32'(rerr), 32'd0);

      // Word 0x10 holds CAFE_F00D for the table and the back-to-back run
      run_txn(0, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, lat, rdat, rerr, leak);
      check32("w10_lat",  32'(lat),  32'd4);
      check32("w10_data", rdat,      32'h5555_5555);
      check32("w10_err",  32'(rerr), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         run_txn(vecs[i].dut_b, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdat, vecs[i].inj,
                 lat, rdat, rerr, leak);
         check32($sformatf("v%0d_lat", i),  32'(lat),  32'(vecs[i].lat));
         check32($sformatf("v%0d_data", i), rdat,      vecs[i].data);
         check32($sformatf("v%0d_err", i),  32'(rerr), 32'(vecs[i].err));
         check32($sformatf("v%0d_errleak", i), 32'(leak), 32'd0);
      end

      // Read held across DONE: a second read starts immediately
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (a_rdy) begin lat = k; rdat = a_rdat; break; end
      end
      check32("b2b_first_lat",  32'(lat), 32'd4);
      check32("b2b_first_data", rdat,     32'hCAFE_F00D);
      @(posedge clk); #1;
      check32("b2b_no_gap", 32'(a_rdy), 32'd0);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (a_rdy) begin lat = k; rdat = a_rdat; break; end
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check32("b2b_second_lat",  32'(lat), 32'd4);
      check32("b2b_second_data", rdat,     32'hCAFE_F00D);
      @(posedge clk); #1;
      check32("b2b_idle_ready", 32'(a_rdy), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
